// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (common with alu_control),
// execution-unit state encoding and shift-step modes.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    function automatic logic [1:0] shift_mode(input logic [3:0] code);
        case (code)
            ALU_SRL: return SH_SRL;
            ALU_SRA: return SH_SRA;
            default: return SH_SLL;
        endcase
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift used once per cycle by the shift iteration.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] din,
    input  logic [1:0]      mode,
    output logic [XLEN-1:0] dout
);

    // One-bit shift selected by mode; SRA replicates the sign bit.
    always_comb begin
        dout = din;
        case (mode)
            SH_SLL:  dout = {din[XLEN-2:0], 1'b0};
            SH_SRL:  dout = {1'b0, din[XLEN-1:1]};
            SH_SRA:  dout = {din[XLEN-1], din[XLEN-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: one operation per handshake, single-cycle logic and
// arithmetic, iterative one-bit-per-cycle shifts, held result until taken.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | in_ready=1, waiting for in_valid
// ST_SHIFT | shifting result one bit per cycle, count holds bits left
// ST_DONE  | out_valid=1, result/zero/illegal held until out_ready
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucontrol,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    state_t            state_q, state_n;
    logic [XLEN-1:0]   result_q, result_n;
    logic [SHW-1:0]    count_q, count_n;
    logic [1:0]        mode_q, mode_n;
    logic              illegal_q, illegal_n;

    logic [XLEN-1:0]   alu_res;
    logic              alu_illegal;
    logic [XLEN-1:0]   shifted;
    logic [SHW-1:0]    shamt;

    // Only the low SHW bits of op_b steer a shift; the rest is ignored.
    assign shamt = op_b[SHW-1:0];

    alu_shift_step #(.XLEN(XLEN)) u_shift_step (
        .din  (result_q),
        .mode (mode_q),
        .dout (shifted)
    );

    // Single-cycle result; shift codes pass op_a through for shamt == 0.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (alucontrol)
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_res = op_a;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  alu_illegal = 1'b1;
        endcase
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_n   = state_q;
        result_n  = result_q;
        count_n   = count_q;
        mode_n    = mode_q;
        illegal_n = illegal_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_shift(alucontrol) && (shamt != '0)) begin
                        result_n  = op_a;
                        count_n   = shamt;
                        mode_n    = shift_mode(alucontrol);
                        illegal_n = 1'b0;
                        state_n   = ST_SHIFT;
                    end else begin
                        result_n  = alu_res;
                        illegal_n = alu_illegal;
                        state_n   = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                result_n = shifted;
                count_n  = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            count_q   <= '0;
            mode_q    <= SH_SLL;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            result_q  <= result_n;
            count_q   <= count_n;
            mode_q    <= mode_n;
            illegal_q <= illegal_n;
        end
    end

    assign result  = result_q;
    assign zero    = (result_q == '0);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations are pushed when an
// operation is driven and popped when the unit hands back a result.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alucontrol;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        zero;
        logic        illegal;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc   = 0;
    int   acc_n  = 0;
    bit   seen   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input string tag);
        exp_t e;
        int   sh;
        sh        = int'(b[4:0]);
        e.tag     = tag;
        e.illegal = 1'b0;
        e.lat     = 1;
        e.res     = '0;
        case (c)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0011: e.res = a ^ b;
            4'b0100: e.res = a << sh;
            4'b0101: e.res = a >> sh;
            4'b0111: e.res = 32'($signed(a) >>> sh);
            4'b1000: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1001: e.res = (a < b) ? 32'd1 : 32'd0;
            default: e.illegal = 1'b1;
        endcase
        if ((c == 4'b0100 || c == 4'b0101 || c == 4'b0111) && sh != 0) e.lat = sh + 1;
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor: latency to first out_valid, then compare on the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                    end else begin
                        if (!seen) begin
                            chk({q[0].tag, "_lat"}, 32'(ncyc - acc_n), 32'(q[0].lat));
                            seen = 1'b1;
                        end
                        if (out_ready) begin
                            e = q.pop_front();
                            chk({e.tag, "_res"}, result, e.res);
                            chk({e.tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
                            chk({e.tag, "_illegal"}, {31'd0, illegal}, {31'd0, e.illegal});
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    acc_n = ncyc;
                    seen  = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("wait_idle", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        @(posedge clk);
        #1;
        q.push_back(model(c, a, b, tag));
        alucontrol = c;
        op_a       = a;
        op_b       = b;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic run(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
        wait_idle();
        send(c, a, b, tag);
        wait_done();
    endtask

    initial begin
        exp_t e;
        logic [3:0] codes [10];
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011,
                  4'b0100, 4'b0101, 4'b0111, 4'b1000, 4'b1001};
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        alucontrol = 4'b0000;
        op_a       = '0;
        op_b       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(4'b0010, 32'd5, 32'd7, "add");
        run(4'b0110, 32'd9, 32'd9, "sub");
        run(4'b1000, 32'hFFFF_FFFF, 32'd1, "slt");
        run(4'b1001, 32'hFFFF_FFFF, 32'd1, "sltu");
        run(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, "and");
        run(4'b0001, 32'hA000_0005, 32'h0500_0050, "or");
        run(4'b0011, 32'hFFFF_0000, 32'hF0F0_F0F0, "xor");
        run(4'b0010, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        run(4'b0101, 32'hF000_0000, 32'hFFFF_FF03, "srl_upper");
        run(4'b0100, 32'hDEAD_BEEF, 32'h0000_0020, "sll0");
        run(4'b1111, 32'h1234_5678, 32'h1, "ill_f");
        run(4'b1010, 32'h1234_5678, 32'h1, "ill_a");
        run(4'b0100, 32'd1, 32'd31, "sll31");

        // SRA with in_valid presented while busy.
        wait_idle();
        send(4'b0111, 32'h8000_0000, 32'd4, "sra");
        for (int i = 0; i < 2; i++) begin
            alucontrol = 4'b0010;
            op_a       = 32'h1111_1111;
            op_b       = 32'h2222_2222;
            in_valid   = 1'b1;
            @(negedge clk);
            chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_done();

        // Backpressure in DONE.
        wait_idle();
        out_ready = 1'b0;
        send(4'b0011, 32'h1234_5678, 32'h0F0F_0F0F, "bp");
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_res", result, q[0].res);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        wait_done();

        // Reset mid-shift aborts the operation.
        wait_idle();
        send(4'b0100, 32'd1, 32'd31, "abort");
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = q.pop_back();
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        run(4'b0000, 32'h0000_00F0, 32'h0000_003C, "and_after_rst");

        for (int i = 0; i < 12; i++) begin
            run(codes[$urandom_range(0, 9)], $urandom, $urandom_range(0, 40), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
